// File: rtl/sar_search.sv
// ---------------------------------------------------------------------------
// sar_search
// Successive-approximation search engine. It drives the B operand of an
// external magnitude comparator whose A operand holds an unknown target.
// It recovers the target one bit per cycle, MSB first, from the comparator
// flags.
//
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   rst    - synchronous active-high reset, overrides everything
//   start  - request a new search (sampled only in IDLE)
//   agb    - comparator flag: target >  probe
//   aeb    - comparator flag: target == probe
//   alb    - comparator flag: target <  probe
//   probe  - registered trial value driven to comparator B (0 when idle)
//   busy   - high while probing
//   done   - one-cycle pulse when a search finishes
//   result - recovered target, held until the next start
//   found  - an exact match (aeb) was seen during the search
//   err    - the search was ended by an illegal flag combination
//   steps  - number of probes issued by the last search
// ---------------------------------------------------------------------------
module sar_search #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             agb,
   input  logic             aeb,
   input  logic             alb,
   output logic [WIDTH-1:0] probe,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             found,
   output logic             err,
   output logic [2:0]       steps
);

   localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PROBE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] mask;       // bit currently under trial
   logic [WIDTH-1:0] kept;       // bits already decided to be 1
   logic [WIDTH-1:0] kept_upd;   // kept bits after this cycle's decision
   logic [WIDTH-1:0] mask_nxt;
   logic             flags_ok;   // exactly one comparator flag is high

   always_comb begin
      flags_ok = 1'b0;
      case ({agb, aeb, alb})
         3'b100, 3'b010, 3'b001: flags_ok = 1'b1;
         default:                flags_ok = 1'b0;
      endcase
      // target > probe means the trial bit belongs in the answer
      kept_upd = agb ? (kept | mask) : (kept & ~mask);
      mask_nxt = mask >> 1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         probe  <= '0;
         mask   <= '0;
         kept   <= '0;
         result <= '0;
         steps  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         found  <= 1'b0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done  <= 1'b0;
               probe <= '0;
               if (start) begin
                  state <= PROBE;
                  probe <= MSB;
                  mask  <= MSB;
                  kept  <= '0;
                  steps <= 3'd1;
                  found <= 1'b0;
                  err   <= 1'b0;
                  busy  <= 1'b1;
               end
            end

            PROBE: begin
               if (!flags_ok || aeb || mask[0]) begin
                  // Search ends this cycle; the reason decides the result.
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  probe <= '0;
                  if (!flags_ok) begin
                     err    <= 1'b1;
                     result <= kept;
                  end else if (aeb) begin
                     found  <= 1'b1;
                     result <= probe;
                  end else begin
                     result <= kept_upd;
                  end
               end else begin
                  mask  <= mask_nxt;
                  kept  <= kept_upd;
                  probe <= kept_upd | mask_nxt;
                  steps <= steps + 3'd1;
               end
            end

            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               probe <= '0;
            end
         endcase
      end
   end

endmodule
